hazard_control_unit: RTL and testbench

Pipeline hazard controller that drives the stall (`write_enable`) and bubble (`flush`) inputs of the IF/ID and ID/EX pipeline registers and the PC write enable. It covers three hazard sources:
- load-use hazards;
- branch operand hazards when branches are resolved in ID;
- structural stalls while the multi-cycle divider is busy.

It sits beside the ID stage. It reads ID-stage register fields and the EX/MEM destination info, and produces same-cycle control for the pipeline registers.

---
 rtl/hazard_control_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller beside the ID stage. Detects load-use hazards,
// branch operand hazards for branches resolved in ID, and structural stalls
// while the multi-cycle divider is occupied. Control outputs are combinational
// from the current inputs and the registered divider state.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles and
// flush_count performance counter outputs.
module hazard_control_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_is_jump,
  input  logic             id_is_div,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             div_start,
  output logic             div_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } div_state_e;

  // Occupancy value loaded on issue; legal DIV_CYCLES fits in 8 bits.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES);

  // A producer register r conflicts with ID when it is non-zero and is
  // actually read as rs or rt (r0 is hard-wired and never a hazard).
  function automatic logic reg_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             use_rs,
    input logic             use_rt
  );
    reg_match = (r != {REG_W{1'b0}}) &&
                ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  div_state_e state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;

  logic load_use_s;
  logic br_ex_s;
  logic br_mem_s;
  logic div_hz_s;
  logic stall_s;
  logic redirect_s;

  assign div_busy = (div_cnt_q != 8'd0);

  // Hazard detection: OR of all stall sources.
  always_comb begin
    load_use_s = ex_mem_read && reg_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    // A load in EX also sets ex_reg_write, so this covers the first cycle of branch-after-load.
    br_ex_s    = id_is_branch && ex_reg_write &&
                 reg_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    br_mem_s   = id_is_branch && mem_mem_read &&
                 reg_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    div_hz_s   = div_busy && (id_reads_hilo || id_is_div);
    stall_s    = load_use_s || br_ex_s || br_mem_s || div_hz_s;
    // Taken-branch outcome is only meaningful for branches; stall masks it below.
    redirect_s = id_is_jump || (id_is_branch && id_branch_taken);
  end

  // Pipeline register control; a stall wins over any branch/jump flush.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    div_start   = 1'b0;
    if (stall_s) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b1;
      div_start   = 1'b0;
    end else begin
      if_id_flush = redirect_s;
      div_start   = id_is_div;
    end
  end

  // Divider occupancy next-state: load on issue, count down while busy.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          div_cnt_d = DIV_LOAD;
          state_d   = S_BUSY;
        end else begin
          div_cnt_d = 8'd0;
          state_d   = S_IDLE;
        end
      end
      S_BUSY: begin
        div_cnt_d = div_cnt_q - 8'd1;
        if (div_cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        div_cnt_d = 8'd0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Divider state register; reset clears the count so div_busy drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit with DIV_CYCLES = 4.
// Stimulus pushes the expected control vector for each cycle; the monitor
// pops and compares on the falling clock edge.
// Vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, div_start, div_busy}
module tb_hazard_control_unit;

  localparam int REG_W = 5;

  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] REDIR  = 6'b111000;
  localparam logic [5:0] ISSUE  = 6'b110010;
  localparam logic [5:0] BUSY   = 6'b110001;
  localparam logic [5:0] BSTALL = 6'b000101;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump;
  logic id_is_div, id_reads_hilo, ex_mem_read, ex_reg_write, mem_mem_read;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, div_start, div_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
  logic [31:0] exp_stall_n = 32'd0;
  logic [31:0] exp_flush_n = 32'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];
  logic [5:0] mon_exp, mon_act;
  string      mon_name;

  hazard_control_unit #(.DIV_CYCLES(4), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .id_is_jump(id_is_jump), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .div_start(div_start), .div_busy(div_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: never hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare one expected vector per cycle on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {pc_write, if_id_write, if_id_flush, id_ex_flush, div_start, div_busy};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", mon_name, mon_act, mon_exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!rst) begin
        n_checks++;
        if (stall_cycles !== exp_stall_n || flush_count !== exp_flush_n) begin
          n_fail++;
          $display("FAIL %s_perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   mon_name, stall_cycles, flush_count, exp_stall_n, exp_flush_n);
        end
        exp_stall_n = exp_stall_n + {31'd0, mon_exp[2]};
        exp_flush_n = exp_flush_n + {31'd0, mon_exp[3]};
      end
`endif
    end
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      exp_stall_n = 32'd0;
      exp_flush_n = 32'd0;
    end
`endif
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    id_branch_taken = 1'b0; id_is_jump = 1'b0; id_is_div = 1'b0;
    id_reads_hilo = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_mem_read = 1'b0;
  endtask

  // Record the expectation for the current inputs, then move to the next cycle
  task automatic cyc(input string nm, input logic [5:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("reset_idle", NORM);

    // Divide then reset mid-count (count = 2)
    id_is_div = 1'b1;
    cyc("pre_rst_issue", ISSUE);
    clr();
    cyc("pre_rst_busy4", BUSY);
    cyc("pre_rst_busy3", BUSY);
    rst = 1'b1;
    cyc("rst_mid_div", NORM);
    rst = 1'b0;
    cyc("post_rst", NORM);

    // Load-use via rs, then the load sits in MEM
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    cyc("load_use_rs", STALL);
    clr();
    id_rs = 5'd8; id_uses_rs = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd8;
    cyc("load_use_release", NORM);
    clr();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd8; id_uses_rs = 1'b1;
    cyc("load_rd0_vs_r8", NORM);
    id_rs = 5'd0;
    cyc("load_r0_vs_r0", NORM);
    clr();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    cyc("load_use_rt", STALL);
    id_uses_rt = 1'b0;
    cyc("load_rt_unused", NORM);

    // Branch after load: two stalls, then one redirect
    clr();
    id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
    cyc("br_load_ex_taken", STALL);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd9;
    cyc("br_load_mem", STALL);
    mem_mem_read = 1'b0;
    cyc("br_load_taken", REDIR);
    clr();
    cyc("br_load_next", NORM);

    // Branch after ALU op: one stall, then redirect
    id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    cyc("br_alu_stall", STALL);
    ex_reg_write = 1'b0; ex_rd = 5'd0; mem_rd = 5'd5;
    cyc("br_alu_taken", REDIR);

    // Branch/jump without hazard
    clr();
    id_is_branch = 1'b1;
    cyc("br_not_taken", NORM);
    id_is_branch = 1'b0; id_branch_taken = 1'b1;
    cyc("taken_no_branch", NORM);
    clr();
    id_is_jump = 1'b1;
    cyc("jump", REDIR);
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
    cyc("jump_under_stall", STALL);

    // Divide with mfhi waiting for the result
    clr();
    id_is_div = 1'b1;
    cyc("div_issue", ISSUE);
    clr();
    id_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) cyc("mfhi_stall", BSTALL);
    cyc("mfhi_release", NORM);

    // Divide held back by load-use, then back-to-back divides
    clr();
    id_is_div = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    cyc("div_vs_load_use", STALL);
    ex_mem_read = 1'b0; ex_rd = 5'd0; mem_mem_read = 1'b1; mem_rd = 5'd3;
    cyc("div_after_stall", ISSUE);
    clr();
    cyc("div2_busy", BUSY);
    id_is_div = 1'b1;
    for (int i = 0; i < 3; i++) cyc("div_during_busy", BSTALL);
    cyc("div_reissue", ISSUE);
    clr();
    for (int i = 0; i < 4; i++) cyc("div3_busy", BUSY);
    cyc("div3_done", NORM);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
